// File: rtl/lcd_pkg.sv
// LCD FIFO read-control shared definitions.
// FSM state encoding and default parameter constants.
package lcd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRIME = 2'd1,
    ST_RUN   = 2'd2
  } rd_state_e;

  localparam int unsigned CNT_W_DEF       = 10;
  localparam int unsigned START_LEVEL_DEF = 128;
  localparam int unsigned SYNC_STAGES_DEF = 2;
  localparam int unsigned UFLOW_CNT_W_DEF = 16;

endpackage

// File: rtl/lcd_sync_bit.sv
// Single-bit multi-flop synchroniser.
// Output is the last flop; latency is STAGES cycles.
module lcd_sync_bit #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sr;

  // shift the async input through the flop chain
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr <= '0;
    end else begin
      sr <= {sr[STAGES-2:0], d};
    end
  end

  assign q = sr[STAGES-1];

endmodule

// File: rtl/lcd_fifo_rd_ctl.sv
// LCD pixel FIFO read controller.
// Primes to a fill level, streams on request, tracks underflow.
module lcd_fifo_rd_ctl
  import lcd_pkg::*;
#(
  parameter int unsigned CNT_W       = CNT_W_DEF,
  parameter int unsigned START_LEVEL = START_LEVEL_DEF,
  parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int unsigned UFLOW_CNT_W = UFLOW_CNT_W_DEF
) (
  input  logic                   fifo_rd_clk,
  input  logic                   rst_n,
  input  logic                   ctl_en,
  input  logic                   rd_data_requst,
  input  logic                   fifo_empty,
  input  logic [CNT_W-1:0]       fifo_rd_cnt,
  input  logic                   clr_status,
  output logic                   fifo_rd_en,
  output logic                   rd_active,
  output logic                   underflow,
  output logic [UFLOW_CNT_W-1:0] underflow_cnt
);

  localparam logic [CNT_W-1:0] START_LVL = CNT_W'(START_LEVEL);
  localparam logic [UFLOW_CNT_W-1:0] UCNT_ONE = UFLOW_CNT_W'(1);

  rd_state_e state;
  logic      req_s;
  logic      filled;
  logic      ufl_evt;

  lcd_sync_bit #(
    .STAGES (SYNC_STAGES)
  ) u_req_sync (
    .clk   (fifo_rd_clk),
    .rst_n (rst_n),
    .d     (rd_data_requst),
    .q     (req_s)
  );

  assign filled  = (fifo_rd_cnt > START_LVL) & ~fifo_empty;
  assign ufl_evt = (state == ST_RUN) & req_s & fifo_empty;

  // read-phase FSM; disable wins over every other transition
  always_ff @(posedge fifo_rd_clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else if (!ctl_en) begin
      state <= ST_IDLE;
    end else begin
      unique case (state)
        ST_IDLE:  state <= ST_PRIME;
        ST_PRIME: if (filled) state <= ST_RUN;
        ST_RUN:   if (ufl_evt) state <= ST_PRIME;
        default:  state <= ST_IDLE;
      endcase
    end
  end

  // sticky underflow flag and saturating event count
  always_ff @(posedge fifo_rd_clk or negedge rst_n) begin
    if (!rst_n) begin
      underflow     <= 1'b0;
      underflow_cnt <= '0;
    end else if (ufl_evt) begin
      underflow <= 1'b1;
      if (clr_status) begin
        underflow_cnt <= UCNT_ONE;
      end else if (!(&underflow_cnt)) begin
        underflow_cnt <= underflow_cnt + UCNT_ONE;
      end
    end else if (clr_status) begin
      underflow     <= 1'b0;
      underflow_cnt <= '0;
    end
  end

  assign rd_active  = (state == ST_RUN);
  assign fifo_rd_en = rd_active & req_s & ~fifo_empty;

endmodule

// File: tb/tb_lcd_fifo_rd_ctl.sv
// Testbench for lcd_fifo_rd_ctl.
// Directed scenarios plus random traffic against a behavioural model.
module tb_lcd_fifo_rd_ctl;

  localparam int CNT_W = 10;
  localparam int START = 128;
  localparam int SS    = 2;
  localparam int UW    = 4;
  localparam int UMAX  = (1 << UW) - 1;

  localparam int PH_IDLE  = 0;
  localparam int PH_PRIME = 1;
  localparam int PH_RUN   = 2;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic             ctl_en = 1'b0;
  logic             req = 1'b0;
  logic             empty = 1'b1;
  logic             clr = 1'b0;
  logic [CNT_W-1:0] cnt = '0;
  logic             rd_en;
  logic             active;
  logic             ufl;
  logic [UW-1:0]    ucnt;

  int n_chk = 0;
  int n_fail = 0;

  int m_phase;
  bit m_ufl;
  int m_ucnt;
  bit m_q[$];

  always #5 clk = ~clk;

  lcd_fifo_rd_ctl #(
    .CNT_W       (CNT_W),
    .START_LEVEL (START),
    .SYNC_STAGES (SS),
    .UFLOW_CNT_W (UW)
  ) dut (
    .fifo_rd_clk    (clk),
    .rst_n          (rst_n),
    .ctl_en         (ctl_en),
    .rd_data_requst (req),
    .fifo_empty     (empty),
    .fifo_rd_cnt    (cnt),
    .clr_status     (clr),
    .fifo_rd_en     (rd_en),
    .rd_active      (active),
    .underflow      (ufl),
    .underflow_cnt  (ucnt)
  );

  task automatic model_reset();
    m_phase = PH_IDLE;
    m_ufl   = 1'b0;
    m_ucnt  = 0;
    m_q.delete();
    for (int i = 0; i < SS; i++) m_q.push_back(1'b0);
  endtask

  function automatic bit exp_active();
    return m_phase == PH_RUN;
  endfunction

  function automatic bit exp_rd_en();
    return (m_phase == PH_RUN) && m_q[0] && !empty;
  endfunction

  // one clock's worth of behaviour from the current inputs
  task automatic model_edge();
    bit ev;
    if (!rst_n) begin
      model_reset();
      return;
    end
    ev = (m_phase == PH_RUN) && m_q[0] && empty;
    if (ev) begin
      m_ufl  = 1'b1;
      m_ucnt = clr ? 1 : ((m_ucnt < UMAX) ? m_ucnt + 1 : UMAX);
    end else if (clr) begin
      m_ufl  = 1'b0;
      m_ucnt = 0;
    end
    if (!ctl_en) m_phase = PH_IDLE;
    else if (m_phase == PH_IDLE) m_phase = PH_PRIME;
    else if (m_phase == PH_PRIME) begin
      if (int'(cnt) > START && !empty) m_phase = PH_RUN;
    end else if (ev) m_phase = PH_PRIME;
    m_q.push_back(req);
    void'(m_q.pop_front());
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    n_chk++;
    if (rd_en !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_rd_en: got %b expected 0", rd_en);
    end
    n_chk++;
    if (active !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_active: got %b expected 0", active);
    end
    n_chk++;
    if (ufl !== 1'b0 || ucnt !== '0) begin
      n_fail++;
      $display("FAIL reset_status: got %b/%0d expected 0/0", ufl, ucnt);
    end
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_prime_threshold();
    ctl_en = 1'b1;
    cnt    = 10'd128;
    empty  = 1'b0;
    req    = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_chk++;
      if (active !== 1'b0 || rd_en !== 1'b0) begin
        n_fail++;
        $display("FAIL prime_128 cyc %0d: got active=%b rd_en=%b expected 0/0",
                 i, active, rd_en);
      end
    end
    cnt = 10'd129;
    tick();
    n_chk++;
    if (active !== 1'b1 || rd_en !== 1'b1) begin
      n_fail++;
      $display("FAIL prime_129: got active=%b rd_en=%b expected 1/1",
               active, rd_en);
    end
  endtask

  task automatic test_hysteresis();
    cnt = 10'd5;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_chk++;
      if (rd_en !== 1'b1 || active !== 1'b1) begin
        n_fail++;
        $display("FAIL hysteresis cyc %0d: got rd_en=%b active=%b expected 1/1",
                 i, rd_en, active);
      end
      tick();
    end
  endtask

  task automatic test_underflow();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    empty = 1'b1;
    #1;
    n_chk++;
    if (rd_en !== 1'b0) begin
      n_fail++;
      $display("FAIL uflow_rd_en: got %b expected 0", rd_en);
    end
    tick();
    n_chk++;
    if (ufl !== 1'b1 || ucnt !== 4'd1) begin
      n_fail++;
      $display("FAIL uflow_status: got %b/%0d expected 1/1", ufl, ucnt);
    end
    n_chk++;
    if (active !== 1'b0) begin
      n_fail++;
      $display("FAIL uflow_leave_run: got %b expected 0", active);
    end
    empty = 1'b0;
    cnt   = 10'd129;
    tick();
    n_chk++;
    if (active !== 1'b1) begin
      n_fail++;
      $display("FAIL uflow_to_prime: got active=%b expected 1", active);
    end
  endtask

  task automatic test_sync_latency();
    req = 1'b0;
    tick();
    tick();
    tick();
    n_chk++;
    if (rd_en !== 1'b0 || active !== 1'b1) begin
      n_fail++;
      $display("FAIL sync_idle_req: got rd_en=%b active=%b expected 0/1",
               rd_en, active);
    end
    req = 1'b1;
    tick();
    n_chk++;
    if (rd_en !== 1'b0) begin
      n_fail++;
      $display("FAIL sync_cyc1: got %b expected 0", rd_en);
    end
    tick();
    n_chk++;
    if (rd_en !== 1'b1) begin
      n_fail++;
      $display("FAIL sync_cyc2: got %b expected 1", rd_en);
    end
  endtask

  task automatic test_clr_coincident();
    empty = 1'b1;
    clr   = 1'b1;
    tick();
    clr = 1'b0;
    n_chk++;
    if (ufl !== 1'b1 || ucnt !== 4'd1) begin
      n_fail++;
      $display("FAIL clr_coincident: got %b/%0d expected 1/1", ufl, ucnt);
    end
    empty = 1'b0;
    clr   = 1'b1;
    tick();
    clr = 1'b0;
    n_chk++;
    if (ufl !== 1'b0 || ucnt !== 4'd0) begin
      n_fail++;
      $display("FAIL clr_only: got %b/%0d expected 0/0", ufl, ucnt);
    end
  endtask

  task automatic test_retain_idle();
    cnt   = 10'd200;
    empty = 1'b0;
    tick();
    empty = 1'b1;
    tick();
    empty  = 1'b0;
    ctl_en = 1'b0;
    tick();
    tick();
    n_chk++;
    if (active !== 1'b0 || ufl !== 1'b1 || ucnt !== 4'd1) begin
      n_fail++;
      $display("FAIL retain_idle: got active=%b ufl=%b cnt=%0d expected 0/1/1",
               active, ufl, ucnt);
    end
  endtask

  task automatic test_saturation();
    ctl_en = 1'b1;
    empty  = 1'b0;
    clr    = 1'b1;
    tick();
    clr = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      empty = 1'b1;
      tick();
      empty = 1'b0;
      if (i == 15 || i == 20) begin
        n_chk++;
        if (ucnt !== 4'd15 || ufl !== 1'b1) begin
          n_fail++;
          $display("FAIL saturate ev %0d: got %b/%0d expected 1/15", i, ufl, ucnt);
        end
      end
    end
  endtask

  task automatic test_reset_mid_run();
    cnt   = 10'd200;
    empty = 1'b0;
    req   = 1'b1;
    tick();
    n_chk++;
    if (rd_en !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_run_pre: got rd_en=%b expected 1", rd_en);
    end
    #3 rst_n = 1'b0;
    model_reset();
    #1;
    n_chk++;
    if (rd_en !== 1'b0 || active !== 1'b0 || ufl !== 1'b0 || ucnt !== '0) begin
      n_fail++;
      $display("FAIL mid_run_rst: got %b %b %b %0d expected all 0",
               rd_en, active, ufl, ucnt);
    end
    tick();
    rst_n = 1'b1;
    #1;
    n_chk++;
    if (active !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_idle: got active=%b expected 0", active);
    end
    tick();
    n_chk++;
    if (active !== 1'b0 || rd_en !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_prime: got %b/%b expected 0/0", active, rd_en);
    end
    tick();
    n_chk++;
    if (active !== 1'b1 || rd_en !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_run: got %b/%b expected 1/1", active, rd_en);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      rst_n  = ($urandom_range(0, 199) != 0);
      ctl_en = ($urandom_range(0, 19) != 0);
      req    = ($urandom_range(0, 9) < 7);
      empty  = ($urandom_range(0, 4) == 0);
      clr    = ($urandom_range(0, 19) == 0);
      cnt    = ($urandom_range(0, 3) == 0) ? CNT_W'($urandom_range(0, 1023))
                                           : CNT_W'($urandom_range(110, 150));
      tick();
      n_chk++;
      if (rd_en !== exp_rd_en()) begin
        n_fail++;
        $display("FAIL rnd_rd_en cyc %0d: got %b expected %b", c, rd_en, exp_rd_en());
      end
      n_chk++;
      if (active !== exp_active()) begin
        n_fail++;
        $display("FAIL rnd_active cyc %0d: got %b expected %b", c, active, exp_active());
      end
      n_chk++;
      if (ufl !== m_ufl) begin
        n_fail++;
        $display("FAIL rnd_ufl cyc %0d: got %b expected %b", c, ufl, m_ufl);
      end
      n_chk++;
      if (ucnt !== UW'(m_ucnt)) begin
        n_fail++;
        $display("FAIL rnd_ucnt cyc %0d: got %0d expected %0d", c, ucnt, m_ucnt);
      end
    end
    rst_n = 1'b1;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_prime_threshold();
    test_hysteresis();
    test_underflow();
    test_sync_latency();
    test_clr_coincident();
    test_retain_idle();
    test_saturation();
    test_reset_mid_run();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
